ieee_int_to_float: RTL and testbench
====================================

Name: ieee_int_to_float

Overview:
- Multi-cycle converter from a 32-bit integer (signed or unsigned) to an IEEE-754 single-precision value.
- Sits directly upstream of ieee_adder and drives its inputA/inputB operand registers, so integer data can enter the float datapath.
- Normalises iteratively, one bit per cycle, then rounds to nearest-even.
- Uses valid/ready handshakes on both sides.

Parameters:
- INT_WIDTH, 32, integer input width. Only 32 is supported; any other value is a configuration error.
- EXP_BIAS, 127, single-precision exponent bias.

Ports:
- clock_in  input  1  system clock; all state is updated on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- in_valid  input  1  in_int and in_signed are valid this cycle.
- in_ready  output 1  block can accept an input; high only in IDLE.
- in_signed  input  1  1 means in_int is two's complement; 0 means unsigned.
- in_int  input  32  integer operand.
- out_valid  output 1  out_float and out_inexact hold a result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_float  output 32  result as {sign, exp[7:0], mant[22:0]}.
- out_inexact  output 1  result was rounded (guard or sticky bit was nonzero).

Behaviour:
- Reset: state goes to IDLE. in_ready=1, out_valid=0, out_float=0, out_inexact=0, and all internal registers clear. Reset mid-conversion aborts the conversion; no partial result is ever presented.
- Handshake:
  - Input transfer happens on a clock edge where in_valid & in_ready.
  - Output transfer happens on a clock edge where out_valid & out_ready.
  - Once raised, out_valid stays high and out_float/out_inexact stay stable until the transfer.
  - After the output transfer, out_float keeps its last value while out_valid=0.
- One conversion in flight at a time. in_ready=0 in every state except IDLE.
- States: IDLE, NORM, ROUND, DONE.
- IDLE, on accept:
  - sign = in_signed & in_int[31].
  - mag (32-bit unsigned) = sign ? (~in_int + 1) : in_int. -2^31 therefore gives mag = 0x80000000.
  - exp (9-bit working register) = EXP_BIAS + 31 = 158.
  - If mag==0, go to DONE with out_float=0x00000000 (always +0, never -0) and out_inexact=0.
  - Otherwise go to NORM.
- NORM, once per cycle:
  - If mag[31]==1, go to ROUND.
  - Otherwise mag <<= 1 and exp -= 1.
  - This takes L+1 cycles, where L = leading-zero count of mag (0..31).
- ROUND:
  - mant = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - Round up when guard & (sticky | mant[0]).
  - If mant+1 overflows 23 bits, mant = 0 and exp += 1.
  - Register out_float = {sign, exp[7:0], mant} and out_inexact = guard | sticky, then go to DONE.
- DONE: out_valid=1. On out_ready, out_valid goes to 0 next cycle and state returns to IDLE. in_ready rises in that same cycle, so a new accept is possible the cycle after the output transfer.
- Latency from the accepting edge to out_valid high:
  - nonzero input: L+3 clocks (max 34, for in_int=1);
  - zero input: 1 clock.
  - Throughput is one result per (latency + 1) cycles when out_ready is held high.
- Range: exp never underflows or overflows, because every 32-bit integer fits in single precision. Largest result is 2^32 exactly, from 0xFFFFFFFF unsigned, giving 0x4F800000.
- in_valid asserted while in_ready=0 is ignored; nothing is captured.

Test Plan:
- Reset checks:
  - Pulse reset_in during NORM → out_valid stays 0.
  - Next cycle: in_ready=1 and out_float=0.
  - A following conversion of 5 completes normally → 0x40A00000.
- Small values and latency:
  - in_int=1 unsigned → out_float=0x3F800000, out_inexact=0, out_valid exactly 34 clocks after accept.
  - in_int=0xFFFFFFFF signed → 0xBF800000.
  - in_int=0 → 0x00000000, out_valid 1 clock after accept.
- Sign boundary on 0x80000000:
  - signed → 0xCF000000;
  - unsigned → 0x4F000000;
  - both with out_inexact=0.
- Rounding:
  - 0x01000001 → 0x4B800000, out_inexact=1 (tie, rounded to even).
  - 0x01000003 → 0x4B800002 (tie, rounded up).
  - 0x7FFFFFFF → 0x4F000000, out_inexact=1 (mantissa overflow bumps exponent).
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid rises → out_float stable, in_ready=0, in_valid pulses ignored.
  - Release out_ready → one transfer, then IDLE.
- Back-to-back stream into ieee_adder:
  - Convert 3 and 4 with out_ready tied high → 0x40400000 and 0x40800000.
  - Feed them as ieee_adder inputA/inputB with add_sub_bit=0 → outputC=0x40E00000 (7.0).

Source files
------------

// File: rtl/ieee_int_to_float.sv
// 32-bit signed/unsigned integer to IEEE-754 single-precision converter.
// Normalises one bit per cycle, then rounds to nearest-even; valid/ready on both sides.
module ieee_int_to_float #(
    parameter int unsigned INT_WIDTH = 32,
    parameter int unsigned EXP_BIAS  = 127
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [INT_WIDTH-1:0] in_int,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_float,
    output logic                 out_inexact
);

    if (INT_WIDTH != 32) begin : gBadWidth
        $error("ieee_int_to_float: INT_WIDTH must be 32");
    end

    localparam logic [8:0] ExpStart = 9'(EXP_BIAS + INT_WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StRound,
        StDone
    } stateT;

    stateT                state;
    logic                 sign;
    logic [INT_WIDTH-1:0] mag;
    logic [8:0]           exp;

    logic                 inSign;
    logic [INT_WIDTH-1:0] magIn;
    logic [22:0]          mantRaw;
    logic                 guardBit;
    logic                 stickyBit;
    logic                 roundUp;
    logic [23:0]          mantSum;
    logic [7:0]           expRounded;

    // Operand capture: magnitude of the incoming integer.
    always_comb begin
        inSign = in_signed & in_int[INT_WIDTH-1];
        magIn  = inSign ? (~in_int + 1'b1) : in_int;
    end

    // Round-to-nearest-even on the normalised magnitude; a carry out of the
    // 23-bit fraction leaves it zero and bumps the exponent by one.
    always_comb begin
        mantRaw    = mag[30:8];
        guardBit   = mag[7];
        stickyBit  = |mag[6:0];
        roundUp    = guardBit & (stickyBit | mantRaw[0]);
        mantSum    = {1'b0, mantRaw} + {23'd0, roundUp};
        expRounded = exp[7:0] + {7'd0, mantSum[23]};
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state       <= StIdle;
            sign        <= 1'b0;
            mag         <= '0;
            exp         <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_float   <= '0;
            out_inexact <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        sign     <= inSign;
                        mag      <= magIn;
                        exp      <= ExpStart;
                        in_ready <= 1'b0;
                        if (magIn == '0) begin
                            // Zero is always +0 and skips normalisation.
                            out_float   <= '0;
                            out_inexact <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= StDone;
                        end else begin
                            state <= StNorm;
                        end
                    end
                end
                StNorm: begin
                    if (mag[INT_WIDTH-1]) begin
                        state <= StRound;
                    end else begin
                        mag <= mag << 1;
                        exp <= exp - 9'd1;
                    end
                end
                StRound: begin
                    out_float   <= {sign, expRounded, mantSum[22:0]};
                    out_inexact <= guardBit | stickyBit;
                    out_valid   <= 1'b1;
                    state       <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ieee_int_to_float.sv
// Directed bench for ieee_int_to_float: literal vectors plus an arithmetic
// reference model checked against the outputs every cycle they are valid.
module tb_ieee_int_to_float;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_signed = 1'b0;
    logic [31:0] in_int = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_float;
    logic        out_inexact;

    int nCompared = 0;
    int nMismatched = 0;
    int cycleCount = 0;

    typedef struct {
        logic [31:0] f;
        logic        inex;
        int          lat;
        int          acc;
    } expT;

    expT expQ[$];
    bit  headSeen = 0;

    ieee_int_to_float #(
        .INT_WIDTH(32),
        .EXP_BIAS (127)
    ) dut (
        .clock_in   (clock_in),
        .reset_in   (reset_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .in_int     (in_int),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_float  (out_float),
        .out_inexact(out_inexact)
    );

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) cycleCount <= cycleCount + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: find the top set bit, then round the discarded tail to nearest-even.
    function automatic void model(input logic [31:0] v, input logic s,
                                  output logic [31:0] f, output logic inex, output int lat);
        bit     neg;
        longint m, q, r, half;
        int     p, e, sh;
        neg = s && v[31];
        m   = neg ? (64'd4294967296 - longint'(v)) : longint'(v);
        f    = '0;
        inex = 1'b0;
        lat  = 1;
        if (m == 0) return;
        p = 0;
        for (int i = 0; i < 33; i++) if (m >= (64'd1 << i)) p = i;
        e = 127 + p;
        if (p > 23) begin
            sh   = p - 23;
            q    = m >> sh;
            r    = m - (q << sh);
            half = 64'd1 << (sh - 1);
            if (r > half || (r == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
            inex = (r != 0);
        end else begin
            q = m << (23 - p);
        end
        f   = {neg, 8'(e), q[22:0]};
        lat = (31 - p) + 3;
    endfunction

    // Compare process: sampled on the falling edge, away from the active edge.
    always @(negedge clock_in) begin
        expT item;
        if (reset_in) begin
            expQ.delete();
            headSeen = 0;
        end else begin
            if (out_valid) begin
                check("handshake in_ready low while out_valid", 32'(in_ready), 32'd0);
                if (expQ.size() == 0) begin
                    check("spurious out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("model out_float", out_float, expQ[0].f);
                    check("model out_inexact", 32'(out_inexact), 32'(expQ[0].inex));
                    if (!headSeen) begin
                        headSeen = 1;
                        check("model latency", 32'(cycleCount - expQ[0].acc + 1),
                              32'(expQ[0].lat));
                    end
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        headSeen = 0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                model(in_int, in_signed, item.f, item.inex, item.lat);
                item.acc = cycleCount + 1;
                expQ.push_back(item);
            end
        end
    end

    task automatic waitReady();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clock_in);
            #1;
            n++;
        end
        if (!in_ready) check("in_ready wait timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic convert(input logic [31:0] v, input logic s, input logic [31:0] ef,
                           input logic ei, input int el);
        int    n;
        string tag;
        tag = $sformatf("%h/%0d", v, s);
        waitReady();
        in_valid  = 1'b1;
        in_signed = s;
        in_int    = v;
        @(posedge clock_in);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clock_in);
            #1;
            n++;
        end
        check({"latency ", tag}, 32'(n), 32'(el));
        check({"out_float ", tag}, out_float, ef);
        check({"out_inexact ", tag}, 32'(out_inexact), 32'(ei));
        if (out_ready) begin
            @(posedge clock_in);
            #1;
            check({"out_valid drop ", tag}, 32'(out_valid), 32'd0);
            check({"in_ready rise ", tag}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clock_in);
        #1;
        reset_in = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_float", out_float, 32'd0);
        check("reset out_inexact", 32'(out_inexact), 32'd0);

        convert(32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 34);
        convert(32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 34);
        convert(32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1);
        convert(32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 3);
        convert(32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0, 3);
        convert(32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 10);
        convert(32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 10);
        convert(32'h7FFF_FFFF, 1'b0, 32'h4F00_0000, 1'b1, 4);
        convert(32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 3);
        convert(32'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 1'b0, 32);

        // Backpressure: result must hold while stray input pulses are ignored.
        out_ready = 1'b0;
        convert(32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 10);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_int   = $urandom;
            @(posedge clock_in);
            #1;
            check("stall out_float", out_float, 32'h4B80_0002);
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock_in);
        #1;
        check("release out_valid", 32'(out_valid), 32'd0);
        check("release in_ready", 32'(in_ready), 32'd1);
        check("release out_float held", out_float, 32'h4B80_0002);
        convert(32'h0000_0006, 1'b0, 32'h40C0_0000, 1'b0, 32);

        // Reset during normalisation aborts without presenting a result.
        waitReady();
        in_valid  = 1'b1;
        in_signed = 1'b0;
        in_int    = 32'h0000_0001;
        @(posedge clock_in);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock_in);
        #1;
        check("pre-abort out_valid", 32'(out_valid), 32'd0);
        reset_in = 1'b1;
        @(posedge clock_in);
        #1;
        reset_in = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort out_float", out_float, 32'd0);
        repeat (40) @(posedge clock_in);
        #1;
        check("abort no late result", 32'(out_valid), 32'd0);
        convert(32'h0000_0005, 1'b0, 32'h40A0_0000, 1'b0, 32);

        // Back-to-back operands for the downstream adder.
        convert(32'h0000_0003, 1'b0, 32'h4040_0000, 1'b0, 33);
        convert(32'h0000_0004, 1'b0, 32'h4080_0000, 1'b0, 32);

        repeat (3) @(posedge clock_in);
        #1;
        check("queue drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
